disp_share_arb: RTL and testbench
=================================

// Module: disp_share_arb
// PURPOSE
//  Round-robin arbiter/scheduler sharing the single 4-digit seven-segment display between N_REQ sources
//  (ALU result, counter FSM, error flags, ...). Registers the winner's 8-bit value and sign and drives the
//  ALU_VAL/SIGN/VALID inputs of the seven-segment driver. Enforces a minimum dwell so a value stays readable,
//  and a maximum hold so no source starves the others.
// PARAMETERS
//  N_REQ     4           number of requesters (2..8)
//  DWELL     25_000_000  min cycles a granted value stays displayed (>=1)
//  MAX_HOLD  100_000_000 max cycles of ownership while another REQ is pending (>DWELL)
//  BLANK_CYC 5_000_000   handover blank length, used only with DISP_ARB_BLANK_EN (>=1)
// PORTS
//  CLK       in  1        system clock
//  RST       in  1        asynchronous reset, active high
//  REQ       in  N_REQ    per-source display request, level, held while the source wants the display
//  VAL_IN    in  8*N_REQ  source i value at [8*i+7:8*i]
//  SIGN_IN   in  N_REQ    source i minus-sign flag
//  GNT       out N_REQ    one-hot grant; all zero when nobody owns the display
//  ALU_VAL   out 8        value to the seven-segment driver
//  SIGN      out 1        sign to the seven-segment driver
//  VALID     out 1        1 = show value; 0 = blank display
//  BUSY      out 1        1 when state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, GNT=0, ALU_VAL=0, SIGN=0, VALID=0, BUSY=0, ptr=N_REQ-1, counters=0.
//  - All outputs are registered. Counters are 32-bit unsigned and saturate, never wrap.
//  - States: IDLE, HOLD, BLANK (BLANK exists only with the macro).
//  - IDLE: if REQ!=0, pick the first set bit searching ptr+1, ptr+2, ... modulo N_REQ. Next edge: GNT=onehot(w),
//    ptr=w, state=HOLD, dwell_cnt=0, hold_cnt=0, VALID=1, ALU_VAL/SIGN = source w inputs.
//    Latency: REQ rise to GNT/VALID is 1 cycle.
//  - HOLD: while REQ[w]=1, ALU_VAL/SIGN reload from source w every cycle (live value).
//    Once REQ[w]=0, the last loaded value stays frozen. dwell_cnt and hold_cnt increment every cycle.
//  - Leave HOLD on the edge where any condition holds:
//    (a) REQ[w]=0 and dwell_cnt>=DWELL-1 (normal release);
//    (b) hold_cnt>=MAX_HOLD-1 and (REQ & ~onehot(w))!=0 (forced release, fairness).
//    A forced-release owner keeping REQ high re-competes with lowest priority, because ptr=w.
//  - On leaving HOLD without the macro: if other requests are pending, re-arbitrate on that same edge
//    (new GNT, no gap, VALID stays 1); else state=IDLE, GNT=0, VALID=0, and ALU_VAL/SIGN keep their last values.
//  - A REQ drop before dwell expires does not shorten the display. A REQ re-rise by the owner during HOLD
//    resumes live updates with no re-grant.
//  - Simultaneous events: an owner release coinciding with new requests follows the round-robin order from ptr+1.
//    Only one GNT bit is ever set.
//  - A REQ that pulses for one cycle in IDLE is granted and displayed for DWELL cycles.
//  - X/0 on VAL_IN of non-granted sources is ignored.
// CONFIGURATION
//  DISP_ARB_BLANK_EN defined:
//    - Every exit from HOLD enters BLANK: GNT=0, VALID=0, blank_cnt=0.
//    - After BLANK_CYC cycles, re-arbitrate as in IDLE on that edge, or go to IDLE if REQ=0.
//    - New requests during BLANK wait. RST in BLANK goes to IDLE.
//  DISP_ARB_BLANK_EN undefined:
//    - No BLANK state; handover is gapless as described under BEHAVIOUR.
// TESTING (bench: DWELL=4, MAX_HOLD=10, BLANK_CYC=3, N_REQ=4)
//  1 Reset then REQ=0001, VAL0=8'd123, SIGN0=1 -> 1 cycle later GNT=0001, ALU_VAL=123, SIGN=1, VALID=1, BUSY=1.
//  2 REQ0 held for 1 cycle only -> VALID=1 for exactly 4 cycles, then IDLE, GNT=0, VALID=0, ALU_VAL stays 123.
//  3 REQ=1111 held, no release -> grants cycle 0001,0010,0100,1000,0001, each held 10 cycles via forced release.
//  4 Owner 2 releases while REQ=0011 pending, ptr=2 -> next GNT=1000? no: REQ3=0, so GNT=0001 on that same edge (no macro).
//  5 DISP_ARB_BLANK_EN: owner releases with REQ1 pending -> VALID=0 and GNT=0 for 3 cycles, then GNT=0010, VALID=1.
//  6 Assert RST mid-HOLD, asynchronously between edges -> GNT=0, VALID=0, ALU_VAL=0 immediately. After RST drops,
//    REQ=1000 -> GNT=1000, because ptr was reset to 3 and 3 is the only requester.

Source files
------------

// File: rtl/disp_share_arb.sv
// disp_share_arb
//   Round-robin scheduler that shares one 4-digit seven-segment display between
//   N_REQ sources. The winner's value/sign are registered and presented to the
//   display driver. A granted value stays up for at least DWELL cycles. An owner
//   that keeps requesting is forced off after MAX_HOLD cycles if anyone else is
//   waiting.
//
//   Optional feature macro: DISP_ARB_BLANK_EN
//     defined   - every handover passes through BLANK_CYC blank cycles
//     undefined - handover is gapless (default build)
//
// Ports
//   CLK      in   system clock
//   RST      in   asynchronous reset, active high
//   REQ      in   [N_REQ]    level request per source
//   VAL_IN   in   [8*N_REQ]  source i value at [8*i+7:8*i]
//   SIGN_IN  in   [N_REQ]    source i minus-sign flag
//   GNT      out  [N_REQ]    one-hot grant, zero when nobody owns the display
//   ALU_VAL  out  [8]        value to the display driver
//   SIGN     out             sign to the display driver
//   VALID    out             1 = show value, 0 = blank
//   BUSY     out             1 whenever the FSM is not idle
//
// States
//   state | meaning
//   IDLE  | nobody owns the display, waiting for any request
//   HOLD  | source ptr owns the display; dwell/hold timers running
//   BLANK | handover gap, display blanked (DISP_ARB_BLANK_EN only)

module disp_share_arb #(
  parameter int N_REQ     = 4,
  parameter int DWELL     = 25_000_000,
  parameter int MAX_HOLD  = 100_000_000,
  parameter int BLANK_CYC = 5_000_000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [8*N_REQ-1:0]   VAL_IN,
  input  logic [N_REQ-1:0]     SIGN_IN,
  output logic [N_REQ-1:0]     GNT,
  output logic [7:0]           ALU_VAL,
  output logic                 SIGN,
  output logic                 VALID,
  output logic                 BUSY
);

  localparam int          PW       = $clog2(N_REQ);
  localparam logic [31:0] DWELL_TC = 32'(DWELL - 1);
  localparam logic [31:0] HOLD_TC  = 32'(MAX_HOLD - 1);
`ifdef DISP_ARB_BLANK_EN
  localparam logic [31:0] BLANK_TC = 32'(BLANK_CYC - 1);
`endif

  if (N_REQ < 2 || N_REQ > 8 || DWELL < 1 || MAX_HOLD <= DWELL || BLANK_CYC < 1) begin : g_param_check
    $error("disp_share_arb: parameter out of range");
  end

`ifdef DISP_ARB_BLANK_EN
  typedef enum logic [1:0] {IDLE, HOLD, BLANK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  state_t           state, state_n;
  logic [PW-1:0]    ptr, ptr_n, pick;
  logic [31:0]      dwell_cnt, dwell_n;
  logic [31:0]      hold_cnt, hold_n;
`ifdef DISP_ARB_BLANK_EN
  logic [31:0]      blank_cnt, blank_n;
`endif
  logic [N_REQ-1:0] gnt_n;
  logic [7:0]       val_n;
  logic             sign_n, valid_n, busy_n;
  logic             do_grant, do_idle, rel_normal, rel_forced;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // First set request bit searching ptr+1, ptr+2, ... wrapping; the previous
  // owner (ptr itself) is examined last, which gives it lowest priority.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [PW-1:0]    p);
    logic [PW-1:0] w;
    logic          found;
    int            idx;
    w     = p;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && req[idx]) begin
        w     = PW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ptr       <= PW'(N_REQ - 1);
      dwell_cnt <= '0;
      hold_cnt  <= '0;
`ifdef DISP_ARB_BLANK_EN
      blank_cnt <= '0;
`endif
      GNT       <= '0;
      ALU_VAL   <= '0;
      SIGN      <= 1'b0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      dwell_cnt <= dwell_n;
      hold_cnt  <= hold_n;
`ifdef DISP_ARB_BLANK_EN
      blank_cnt <= blank_n;
`endif
      GNT       <= gnt_n;
      ALU_VAL   <= val_n;
      SIGN      <= sign_n;
      VALID     <= valid_n;
      BUSY      <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    dwell_n    = dwell_cnt;
    hold_n     = hold_cnt;
`ifdef DISP_ARB_BLANK_EN
    blank_n    = blank_cnt;
`endif
    gnt_n      = GNT;
    val_n      = ALU_VAL;
    sign_n     = SIGN;
    valid_n    = VALID;
    do_grant   = 1'b0;
    do_idle    = 1'b0;
    rel_normal = 1'b0;
    rel_forced = 1'b0;
    pick       = rr_pick(REQ, ptr);

    case (state)
      IDLE: do_grant = |REQ;

      HOLD: begin
        dwell_n = sat_inc(dwell_cnt);
        hold_n  = sat_inc(hold_cnt);
        // Live value while the owner requests; frozen once it lets go.
        if (REQ[ptr]) begin
          val_n  = VAL_IN[int'(ptr)*8 +: 8];
          sign_n = SIGN_IN[ptr];
        end
        rel_normal = !REQ[ptr] && (dwell_cnt >= DWELL_TC);
        rel_forced = (hold_cnt >= HOLD_TC) && ((REQ & ~GNT) != '0);
        if (rel_normal || rel_forced) begin
`ifdef DISP_ARB_BLANK_EN
          state_n = BLANK;
          gnt_n   = '0;
          valid_n = 1'b0;
          blank_n = '0;
`else
          if (|REQ) do_grant = 1'b1;
          else      do_idle  = 1'b1;
`endif
        end
      end

`ifdef DISP_ARB_BLANK_EN
      BLANK: begin
        blank_n = sat_inc(blank_cnt);
        if (blank_cnt >= BLANK_TC) begin
          if (|REQ) do_grant = 1'b1;
          else      do_idle  = 1'b1;
        end
      end
`endif

      default: do_idle = 1'b1;
    endcase

    if (do_grant) begin
      state_n     = HOLD;
      ptr_n       = pick;
      gnt_n       = '0;
      gnt_n[pick] = 1'b1;
      val_n       = VAL_IN[int'(pick)*8 +: 8];
      sign_n      = SIGN_IN[pick];
      valid_n     = 1'b1;
      dwell_n     = '0;
      hold_n      = '0;
    end else if (do_idle) begin
      state_n = IDLE;
      gnt_n   = '0;
      valid_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_disp_share_arb.sv
// Bench for disp_share_arb with DWELL=4, MAX_HOLD=10, BLANK_CYC=3, N_REQ=4.
// A cycle-level reference model (owner / cycles shown / blank cycles) is
// compared with the DUT on every falling edge; directed literal checks pin
// the headline scenarios.

module tb_disp_share_arb;
  localparam int N         = 4;
  localparam int DWELL     = 4;
  localparam int MAX_HOLD  = 10;
  localparam int BLANK_CYC = 3;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ;
  logic [8*N-1:0] VAL_IN;
  logic [N-1:0]   SIGN_IN;
  logic [N-1:0]   GNT;
  logic [7:0]     ALU_VAL;
  logic           SIGN, VALID, BUSY;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  disp_share_arb #(.N_REQ(N), .DWELL(DWELL), .MAX_HOLD(MAX_HOLD), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .VAL_IN(VAL_IN), .SIGN_IN(SIGN_IN),
    .GNT(GNT), .ALU_VAL(ALU_VAL), .SIGN(SIGN), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: who owns the display, how long it has been shown,
  // and whether a handover gap is in progress.
  int       m_owner = -1;
  int       m_ptr = N - 1;
  int       m_shown = 0;
  bit       m_blanking = 1'b0;
  int       m_blank_shown = 0;
  logic [7:0] m_val = 8'd0;
  logic     m_sign = 1'b0;
  bit       m_others, m_leave;

  task automatic m_try_grant();
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (REQ[idx]) begin
        m_owner = idx;
        m_ptr   = idx;
        m_shown = 0;
        m_val   = VAL_IN[idx*8 +: 8];
        m_sign  = SIGN_IN[idx];
        return;
      end
    end
  endtask

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_owner = -1; m_ptr = N - 1; m_shown = 0;
      m_blanking = 1'b0; m_blank_shown = 0;
      m_val = 8'd0; m_sign = 1'b0;
    end else if (m_owner >= 0) begin
      m_shown++;
      if (REQ[m_owner]) begin
        m_val  = VAL_IN[m_owner*8 +: 8];
        m_sign = SIGN_IN[m_owner];
      end
      m_others = (REQ & ~(4'b0001 << m_owner)) != 4'b0000;
      m_leave  = (!REQ[m_owner] && m_shown >= DWELL) || (m_shown >= MAX_HOLD && m_others);
      if (m_leave) begin
        m_owner = -1;
`ifdef DISP_ARB_BLANK_EN
        m_blanking = 1'b1;
        m_blank_shown = 0;
`else
        m_try_grant();
`endif
      end
    end else if (m_blanking) begin
      m_blank_shown++;
      if (m_blank_shown >= BLANK_CYC) begin
        m_blanking = 1'b0;
        m_try_grant();
      end
    end else begin
      m_try_grant();
    end
  end

  logic [14:0] exp_vec, act_vec;
  always @(negedge CLK) begin
    if (chk_en) begin
      exp_vec = {(m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000,
                 m_val, m_sign, (m_owner >= 0), (m_owner >= 0) || m_blanking};
      act_vec = {GNT, ALU_VAL, SIGN, VALID, BUSY};
      checks++;
      if (act_vec !== exp_vec) begin
        errors++;
        $display("FAIL model_cycle t=%0t got gnt=%b val=%0d sign=%b valid=%b busy=%b expected %h",
                 $time, GNT, ALU_VAL, SIGN, VALID, BUSY, exp_vec);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk(name, {31'd0, BUSY}, 32'd0);
  endtask

  int cnt, gaps;

  initial begin
    RST = 1'b1; REQ = '0; VAL_IN = '0; SIGN_IN = '0;
    repeat (2) @(negedge CLK);
    chk_en = 1'b1;
    chk("rst_gnt", {28'd0, GNT}, 0);
    chk("rst_valid", {31'd0, VALID}, 0);
    chk("rst_busy", {31'd0, BUSY}, 0);
    chk("rst_val", {24'd0, ALU_VAL}, 0);
    RST = 1'b0;

    // 1: single request, one cycle latency
    @(negedge CLK);
    REQ = 4'b0001; VAL_IN[7:0] = 8'd123; SIGN_IN[0] = 1'b1;
    @(negedge CLK);
    chk("t1_gnt", {28'd0, GNT}, 32'b0001);
    chk("t1_val", {24'd0, ALU_VAL}, 123);
    chk("t1_sign", {31'd0, SIGN}, 1);
    chk("t1_valid", {31'd0, VALID}, 1);
    chk("t1_busy", {31'd0, BUSY}, 1);

    // 2: one-cycle pulse still shown for DWELL cycles, value frozen
    REQ = 4'b0000; VAL_IN[7:0] = 8'd55;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (VALID) cnt++;
      else break;
    end
    chk("t2_dwell_len", cnt, 4);
    chk("t2_gnt", {28'd0, GNT}, 0);
    chk("t2_val_kept", {24'd0, ALU_VAL}, 123);

    // 3: all requesting, forced release every MAX_HOLD cycles (ptr now 0)
    REQ = 4'b1111; VAL_IN = {8'd40, 8'd30, 8'd20, 8'd10}; SIGN_IN = 4'b0101;
    gaps = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge CLK);
      if (!VALID) gaps++;
      case (k)
        0:  chk("t3_k0", {28'd0, GNT}, 32'b0010);
        9:  chk("t3_k9", {28'd0, GNT}, 32'b0010);
        10: begin
              chk("t3_k10", {28'd0, GNT}, 32'b0100);
              chk("t3_k10_val", {24'd0, ALU_VAL}, 30);
            end
        20: chk("t3_k20", {28'd0, GNT}, 32'b1000);
        30: chk("t3_k30", {28'd0, GNT}, 32'b0001);
        40: chk("t3_k40", {28'd0, GNT}, 32'b0010);
        default: ;
      endcase
    end
`ifndef DISP_ARB_BLANK_EN
    chk("t3_gapless", gaps, 0);
`endif
    REQ = 4'b0000;
    wait_idle("t3_idle_timeout");

    // 4: owner 2 releases while 0011 pending -> source 0 next
    REQ = 4'b0100;
    @(negedge CLK);
    chk("t4_gnt2", {28'd0, GNT}, 32'b0100);
    REQ = 4'b0011;
    repeat (3) @(negedge CLK);
    chk("t4_still2", {28'd0, GNT}, 32'b0100);
    chk("t4_frozen", {24'd0, ALU_VAL}, 30);
    @(negedge CLK);
`ifdef DISP_ARB_BLANK_EN
    chk("t4_blank_gnt", {28'd0, GNT}, 0);
    chk("t4_blank_valid", {31'd0, VALID}, 0);
    repeat (2) @(negedge CLK);
    chk("t4_blank_end_valid", {31'd0, VALID}, 0);
    @(negedge CLK);
`endif
    chk("t4_gnt0", {28'd0, GNT}, 32'b0001);
    chk("t4_valid", {31'd0, VALID}, 1);
    chk("t4_val", {24'd0, ALU_VAL}, 10);

    // 5: owner 0 releases with source 1 pending
    REQ = 4'b0010;
    repeat (3) @(negedge CLK);
    chk("t5_still0", {28'd0, GNT}, 32'b0001);
    @(negedge CLK);
`ifdef DISP_ARB_BLANK_EN
    chk("t5_blank_gnt", {28'd0, GNT}, 0);
    chk("t5_blank_valid", {31'd0, VALID}, 0);
    repeat (2) @(negedge CLK);
    chk("t5_blank_end", {28'd0, GNT}, 0);
    @(negedge CLK);
`endif
    chk("t5_gnt1", {28'd0, GNT}, 32'b0010);
    chk("t5_val", {24'd0, ALU_VAL}, 20);

    // 6: asynchronous reset mid-HOLD, then ptr back at N-1
    @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("t6_gnt", {28'd0, GNT}, 0);
    chk("t6_valid", {31'd0, VALID}, 0);
    chk("t6_val", {24'd0, ALU_VAL}, 0);
    chk("t6_busy", {31'd0, BUSY}, 0);
    @(negedge CLK);
    RST = 1'b0; REQ = 4'b1000;
    @(negedge CLK);
    chk("t6_gnt3", {28'd0, GNT}, 32'b1000);
    chk("t6_val3", {24'd0, ALU_VAL}, 40);
    REQ = 4'b0000;
    wait_idle("t6_idle_timeout");

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
